// File: rtl/pulse_pkg.sv
// pulse_pkg: shared state encoding and default timing for the pulse generator.
package pulse_pkg;
    typedef enum logic [1:0] {DELAY, HIGH, DONE} state_t;
    localparam int unsigned DLY_DEF = 3;
    localparam int unsigned LEN_DEF = 2;
endpackage

// File: rtl/pulse_if.sv
// pulse_if: arm request and status outputs of the pulse generator.
interface pulse_if;
    logic arm;
    logic pulse;
    logic busy;
    logic done;
    modport master(output arm, input pulse, busy, done);
    modport slave(input arm, output pulse, busy, done);
endinterface

// File: rtl/pulse_ctr.sv
// pulse_ctr: W-bit counter with sync clear, increment and terminal compare.
module pulse_ctr #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    input  logic [W-1:0] i_term,
    output logic         o_hit
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_inc) r_cnt <= r_cnt + 1'b1;
    assign o_hit = r_cnt == i_term;
endmodule

// File: rtl/pulse.sv
// pulse: single-shot pulse of len cycles, dly cycles after reset release or re-arm.
module pulse
    import pulse_pkg::*;
#(
    parameter int unsigned dly = DLY_DEF,
    parameter int unsigned len = LEN_DEF,
    parameter int          W   = 32
) (
    input logic clk,
    input logic rst,
    pulse_if.slave bus
);
    state_t       r_state;
    logic         r_pulse, r_busy, r_done;
    logic         w_hit;
    logic [W-1:0] w_term;
    // the counter is cleared on every state exit and held at zero in DONE
    assign w_term = (r_state == HIGH) ? W'(len - 1) : W'(dly);
    pulse_ctr #(.W(W)) u_ctr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (r_state == DONE || w_hit),
        .i_inc (r_state != DONE),
        .i_term(w_term),
        .o_hit (w_hit)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state <= DELAY;
            r_pulse <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                DELAY: if (w_hit) begin
                    r_state <= (len == 0) ? DONE : HIGH;
                    r_pulse <= len != 0;
                    r_busy  <= len != 0;
                    r_done  <= len == 0;
                end
                HIGH: if (w_hit) begin
                    r_state <= DONE;
                    r_pulse <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                DONE: if (bus.arm) begin
                    r_state <= DELAY;
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                end
                default: r_state <= DELAY;
            endcase
        end
    assign bus.pulse = r_pulse;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
endmodule

// File: tb/tb_pulse.sv
// tb_pulse: directed checks of the pulse generator over several parameter sets.
module tb_pulse;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk = ~clk;

    pulse_if ia();
    pulse_if ib();
    pulse_if ic();
    pulse_if id();
    pulse #(.dly(3), .len(2), .W(32)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    pulse #(.dly(0), .len(1), .W(32)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
    pulse #(.dly(5), .len(0), .W(32)) dut_c (.clk(clk), .rst(rst), .bus(ic.slave));
    pulse #(.dly(200), .len(100), .W(8)) dut_d (.clk(clk), .rst(rst), .bus(id.slave));

    typedef struct {
        logic arm;
        logic p;
        logic b;
        logic d;
    } vec_t;
    vec_t tv[15];

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic exp_p(input int e, input int dl, input int ln);
        return e >= dl + 1 && e < dl + 1 + ln;
    endfunction

    function automatic logic exp_d(input int e, input int dl, input int ln);
        return e >= dl + 1 + ln;
    endfunction

    task automatic chk_seq_a(input string tag, input int edges);
        for (int e = 1; e <= edges; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s pulse e%0d", tag, e), ia.pulse, exp_p(e, 3, 2));
            chk($sformatf("%s done e%0d", tag, e), ia.done, exp_d(e, 3, 2));
            chk($sformatf("%s busy e%0d", tag, e), ia.busy, !exp_d(e, 3, 2));
        end
    endtask

    initial begin
        // arm pulses at edges 2 and 5 fall in DELAY/HIGH and must be ignored
        tv[0]  = '{0, 0, 1, 0};
        tv[1]  = '{1, 0, 1, 0};
        tv[2]  = '{0, 0, 1, 0};
        tv[3]  = '{0, 1, 1, 0};
        tv[4]  = '{1, 1, 1, 0};
        tv[5]  = '{0, 0, 0, 1};
        tv[6]  = '{0, 0, 0, 1};
        tv[7]  = '{1, 0, 1, 0};
        tv[8]  = '{0, 0, 1, 0};
        tv[9]  = '{0, 0, 1, 0};
        tv[10] = '{0, 0, 1, 0};
        tv[11] = '{0, 1, 1, 0};
        tv[12] = '{0, 1, 1, 0};
        tv[13] = '{0, 0, 0, 1};
        tv[14] = '{0, 0, 0, 1};
        ia.arm = 1'b0;
        ib.arm = 1'b0;
        ic.arm = 1'b0;
        id.arm = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset pulse", ia.pulse, 1'b0);
        chk("reset busy", ia.busy, 1'b1);
        chk("reset done", ia.done, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            ia.arm = tv[i].arm;
            @(posedge clk);
            #1;
            chk($sformatf("tbl pulse e%0d", i + 1), ia.pulse, tv[i].p);
            chk($sformatf("tbl busy e%0d", i + 1), ia.busy, tv[i].b);
            chk($sformatf("tbl done e%0d", i + 1), ia.done, tv[i].d);
            @(negedge clk);
        end
        ia.arm = 1'b0;

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 305; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("d0l1 pulse e%0d", e), ib.pulse, exp_p(e, 0, 1));
            chk($sformatf("d0l1 done e%0d", e), ib.done, exp_d(e, 0, 1));
            chk($sformatf("d5l0 pulse e%0d", e), ic.pulse, 1'b0);
            chk($sformatf("d5l0 done e%0d", e), ic.done, exp_d(e, 5, 0));
            chk($sformatf("wide pulse e%0d", e), id.pulse, exp_p(e, 200, 100));
            chk($sformatf("wide done e%0d", e), id.done, exp_d(e, 200, 100));
        end

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midpulse high", ia.pulse, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("midpulse async drop", ia.pulse, 1'b0);
        chk("midpulse async busy", ia.busy, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        chk_seq_a("after mid", 8);

        @(negedge clk);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("short rst busy", ia.busy, 1'b1);
        chk("short rst done", ia.done, 1'b0);
        chk_seq_a("after short", 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
